// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROL = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Start/done handshake bundle between the ALU control path and the shift sequencer.
interface shift_sequencer_if #(
    parameter int unsigned N = 4
) ();
    import shift_pkg::*;

    logic            start;
    shift_op_t       op;
    logic [N-1:0]    aIn;
    logic [N-1:0]    shamt;
    logic            busy;
    logic            done;
    logic [N-1:0]    result;

    modport master (
        output start, op, aIn, shamt,
        input  busy, done, result
    );

    modport slave (
        input  start, op, aIn, shamt,
        output busy, done, result
    );

endinterface

// File: rtl/shift_step1.sv
// Single-position shift/rotate step; the only datapath shifter in the sequencer.
module shift_step1
    import shift_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] acc_i,
    input  shift_op_t    op_i,
    output logic [N-1:0] acc_o
);

    always_comb begin
        acc_o = acc_i;
        unique case (op_i)
            SLL:     acc_o = {acc_i[N-2:0], 1'b0};
            SRL:     acc_o = {1'b0, acc_i[N-1:1]};
            SRA:     acc_o = {acc_i[N-1], acc_i[N-1:1]};
            ROL:     acc_o = {acc_i[N-2:0], acc_i[N-1]};
            default: acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative shifter: applies one shift step per clock, counting down the effective amount.
// Out-of-range amounts are clamped on accept and complete in a single cycle.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic              clk,
    input  logic              rst,
    shift_sequencer_if.slave  bus
);

    localparam int unsigned LW = $clog2(N);

    state_t       state_q, state_d;
    shift_op_t    op_q, op_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] result_q, result_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [N-1:0] step_out;
    logic [N-1:0] eff;
    logic [N-1:0] load_acc;
    logic         accept;
    logic         over_range;

    shift_step1 #(.N(N)) u_step (
        .acc_i (acc_q),
        .op_i  (op_q),
        .acc_o (step_out)
    );

    // Any bit at or above log2(N) means the amount is at least N.
    assign over_range = |bus.shamt[N-1:LW];
    assign accept     = bus.start && (state_q != SHIFT);

    // Fast-path clamp: rotates wrap, shifts saturate to zero or the sign fill.
    always_comb begin
        eff      = bus.shamt;
        load_acc = bus.aIn;
        if (bus.op == ROL) begin
            eff = N'(bus.shamt[LW-1:0]);
        end else if (over_range) begin
            eff      = '0;
            load_acc = (bus.op == SRA) ? {N{bus.aIn[N-1]}} : '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        if (state_q == SHIFT) begin
            acc_d = step_out;
            cnt_d = cnt_q - N'(1);
            if (cnt_q == N'(1)) begin
                state_d  = DONE;
                result_d = step_out;
                done_d   = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else if (accept) begin
            op_d  = bus.op;
            acc_d = load_acc;
            if (eff == '0) begin
                state_d  = DONE;
                cnt_d    = '0;
                result_d = load_acc;
                done_d   = 1'b1;
            end else begin
                state_d = SHIFT;
                cnt_d   = eff;
                busy_d  = 1'b1;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= SLL;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (N=4): latency, clamping, start handling and reset abort.
module tb_shift_sequencer;
    import shift_pkg::*;

    localparam int unsigned N = 4;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [N-1:0] prev_res;

    shift_sequencer_if #(.N(N)) bus ();

    shift_sequencer #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input shift_op_t op, input logic [N-1:0] a, input logic [N-1:0] sh);
        bus.op    = op;
        bus.aIn   = a;
        bus.shamt = sh;
        bus.start = 1'b1;
    endtask

    // Start in cycle 0, then check busy over cycles 1..eff and done in cycle eff+1.
    task automatic run_op(input string tag, input shift_op_t op, input logic [N-1:0] a,
                          input logic [N-1:0] sh, input int eff, input logic [N-1:0] exp);
        drive(op, a, sh);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= eff; c++) begin
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_nodone"}, 32'(bus.done), 32'd0);
            check({tag, "_hold"}, 32'(bus.result), 32'(prev_res));
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
        check({tag, "_res"}, 32'(bus.result), 32'(exp));
        prev_res = exp;
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        check({tag, "_stable"}, 32'(bus.result), 32'(exp));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        prev_res     = '0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.op       = SLL;
        bus.aIn      = '0;
        bus.shamt    = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_res", 32'(bus.result), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("sll2",  SLL, 4'b0011, 4'd2, 2, 4'b1100);
        run_op("sra3",  SRA, 4'b1000, 4'd3, 3, 4'b1111);
        run_op("srl3",  SRL, 4'b1000, 4'd3, 3, 4'b0001);
        run_op("srl5",  SRL, 4'b1111, 4'd5, 0, 4'b0000);
        run_op("sra4",  SRA, 4'b1010, 4'd4, 0, 4'b1111);
        run_op("rol6",  ROL, 4'b1001, 4'd6, 2, 4'b0110);
        run_op("sll15", SLL, 4'b0101, 4'd15, 0, 4'b0000);
        run_op("rol4",  ROL, 4'b1011, 4'd4, 0, 4'b1011);

        // Start during SHIFT must be ignored.
        drive(SLL, 4'b0001, 4'd3);
        @(negedge clk);
        bus.start = 1'b0;
        check("ign_c1_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        drive(SRL, 4'b1111, 4'd0);
        check("ign_c2_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        check("ign_c3_busy", 32'(bus.busy), 32'd1);
        check("ign_c3_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("ign_c4_done", 32'(bus.done), 32'd1);
        check("ign_c4_res", 32'(bus.result), 32'b1000);
        @(negedge clk);
        check("ign_c5_done", 32'(bus.done), 32'd0);
        check("ign_c5_busy", 32'(bus.busy), 32'd0);

        // Back-to-back: starts raised in DONE cycles are taken with no gap.
        drive(SLL, 4'b0001, 4'd1);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_c1_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("b2b_c2_done", 32'(bus.done), 32'd1);
        check("b2b_c2_res", 32'(bus.result), 32'b0010);
        drive(SRL, 4'b1100, 4'd2);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_c3_busy", 32'(bus.busy), 32'd1);
        check("b2b_c3_done", 32'(bus.done), 32'd0);
        check("b2b_c3_hold", 32'(bus.result), 32'b0010);
        @(negedge clk);
        check("b2b_c4_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("b2b_c5_done", 32'(bus.done), 32'd1);
        check("b2b_c5_res", 32'(bus.result), 32'b0011);
        drive(SRA, 4'b1000, 4'd7);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_c6_done", 32'(bus.done), 32'd1);
        check("b2b_c6_busy", 32'(bus.busy), 32'd0);
        check("b2b_c6_res", 32'(bus.result), 32'b1111);
        @(negedge clk);
        check("b2b_c7_done", 32'(bus.done), 32'd0);
        check("b2b_c7_res", 32'(bus.result), 32'b1111);

        // Reset in the middle of a shift aborts without a done pulse.
        drive(SLL, 4'b0001, 4'd3);
        @(negedge clk);
        bus.start = 1'b0;
        check("abort_c1_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_res", 32'(bus.result), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("abort_nodone", 32'(bus.done), 32'd0);
            check("abort_nobusy", 32'(bus.busy), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift controller for the ALU.
- Performs a shift or rotate of an N-bit operand by iterating a 1-position shift step once per clock, counting down the shift amount.
- Uses a start/done handshake so the ALU control path can share one small shift step instead of a full barrel shifter.
- Handles out-of-range shift amounts in a single fast-path cycle.

Parameters:
N, 4, operand and shift-amount width; must be a power of two, N >= 2.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled on rising edge of clk when the block is not busy
op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL
aIn  input  N  operand, sampled with start
shamt  input  N  shift amount (unsigned), sampled with start
busy  output  1  high while in SHIFT state
done  output  1  one-cycle pulse; result valid
result  output  N  shifted value; held until the next accepted start

Behaviour:
- Reset (synchronous, active-high): state=IDLE, result=0, busy=0, done=0, internal counter=0.
- FSM states: IDLE, SHIFT, DONE.
- Start is accepted in IDLE or DONE when start=1. Start in SHIFT is ignored, with no side effects.
- Effective amount (eff) and initial accumulator load on accept:
  - ROL: eff = shamt mod N (low log2(N) bits); acc = aIn.
  - SLL/SRL with shamt >= N: eff = 0; acc = 0.
  - SRA with shamt >= N: eff = 0; acc = all bits equal to aIn[N-1].
  - Otherwise: eff = shamt; acc = aIn.
- Transitions on accept: eff == 0 -> DONE; else -> SHIFT with cnt = eff.
- SHIFT state:
  - Each cycle, acc = step(acc, op), cnt = cnt - 1.
  - When cnt == 1 before the decrement (last shift), go to DONE.
- Step operations:
  - SLL: {acc[N-2:0],0}
  - SRL: {0,acc[N-1:1]}
  - SRA: {acc[N-1],acc[N-1:1]}
  - ROL: {acc[N-2:0],acc[N-1]}
- DONE state:
  - done=1 and result=acc for this cycle.
  - Next state is the accept target if start=1, else IDLE.
- Latency:
  - With start high in cycle 0, done is high in cycle eff+1.
  - busy is high in cycles 1..eff.
  - eff=0 gives done in cycle 1 with busy never asserted.
- result register:
  - Updates only on entry to DONE; stable in IDLE.
  - done and busy are never high together.
- Throughput: back-to-back operations are possible; start asserted in the DONE cycle is accepted, with no idle gap.
- Reset mid-operation: abort immediately; no done pulse; result returns to 0.
- Counter width is N bits; eff <= N-1 after clamping, so the counter cannot underflow.

Decomposition:
- Package shift_pkg:
  - shift_op_t enum {SLL=2'b00, SRL=2'b01, SRA=2'b10, ROL=2'b11}
  - state_t enum {IDLE, SHIFT, DONE}
- Sub-module shift_step1: combinational, parameterised N. Inputs acc and op; output is the 1-position result. It is instantiated once and is the only datapath shifter.
- FSM, counter and fast-path clamp logic live in shift_sequencer.

Test Plan (N=4, start high in cycle 0):
- SLL, aIn=0011, shamt=2 -> busy high in cycles 1-2; done high in cycle 3 only; result=1100.
- SRA, aIn=1000, shamt=3 -> done in cycle 4; result=1111. SRL with the same inputs -> result=0001.
- SRL, aIn=1111, shamt=5 -> done in cycle 1; result=0000; busy never high. SRA, aIn=1010, shamt=4 -> done in cycle 1; result=1111.
- ROL, aIn=1001, shamt=6 -> eff=2; done in cycle 3; result=0110.
- Start handling:
  - SLL 0001 by 3 started; start pulsed again in cycle 2 with different data -> ignored; done in cycle 4, result=1000.
  - Start asserted in the done cycle -> accepted; second done follows with no gap.
- SLL 0001 by 3, then rst=1 in cycle 2 -> cycle 3: state IDLE, busy=0, done=0, result=0; no done pulse afterwards.
